mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter AW, default 32, bus address width.
REQ-002 The block SHALL have parameter DW, default 32, bus data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, maximum bus cycles awaiting ack (1..15).
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port if_req  input  1  instruction-fetch request, held until if_done/if_err.
REQ-007 The block SHALL have port if_addr  input  AW  fetch address.
REQ-008 The block SHALL have port if_gnt  output  1  fetch transaction on bus.
REQ-009 The block SHALL have port if_rdata  output  DW  fetched word.
REQ-010 The block SHALL have port if_done  output  1  one-cycle fetch-complete pulse.
REQ-011 The block SHALL have port if_err  output  1  one-cycle fetch-timeout pulse.
REQ-012 The block SHALL have port d_req  input  1  load/store request, held until d_done/d_err.
REQ-013 The block SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-014 The block SHALL have port d_addr  input  AW  data address.
REQ-015 The block SHALL have port d_wdata  input  DW  store data.
REQ-016 The block SHALL have ports d_gnt, d_rdata, d_done, d_err  output  1/DW/1/1  data-side equivalents of REQ-008..011.
REQ-017 The block SHALL have ports cyc_o, stb_o, we_o  output  1  bus cycle, strobe, write enable.
REQ-018 The block SHALL have ports adr_o  output  AW, dat_o  output  DW, dat_i  input  DW, ack_i  input  1  bus address, write data, read data, acknowledge.

Function
REQ-019 The FSM SHALL have states IDLE, IF_BUS, D_BUS; all outputs registered.
REQ-020 In IDLE with only d_req high, the block SHALL latch d_addr/d_we/d_wdata and enter D_BUS next edge.
REQ-021 In IDLE with only if_req high, the block SHALL latch if_addr, we=0, and enter IF_BUS next edge.
REQ-022 With both requests high in IDLE, the block SHALL grant the requester not served last (last_srv flag, updated on each done or err).
REQ-023 In IF_BUS/D_BUS, cyc_o=stb_o=1, adr_o/dat_o/we_o SHALL come from latched values; the matching gnt SHALL be 1.
REQ-024 Requests SHALL be sampled only in IDLE; input changes during a bus state SHALL NOT affect the transaction in progress.
REQ-025 On ack_i in a bus state, the block SHALL drop cyc_o/stb_o/gnt, pulse the matching done for exactly one cycle, and return to IDLE.
REQ-026 On a load or fetch ack, dat_i SHALL be captured into d_rdata/if_rdata; a store ack SHALL leave d_rdata unchanged; rdata SHALL hold until the next read ack for that requester.
REQ-027 Latency: request first seen in IDLE at edge N SHALL produce stb_o=1 from N+1; ack_i sampled at edge M SHALL produce done=1 during the cycle after M; minimum request-to-done 2 cycles.
REQ-028 A 4-bit wait counter SHALL clear on entering a bus state and increment each bus-state cycle without ack_i.
REQ-029 When the counter equals TIMEOUT with ack_i low, the block SHALL end the bus cycle, pulse the matching err (never done), leave rdata unchanged, and return to IDLE.
REQ-030 ack_i and counter==TIMEOUT in the same cycle SHALL be treated as a normal ack.
REQ-031 ack_i while in IDLE SHALL be ignored.
REQ-032 After every transaction, stb_o SHALL be low for at least one cycle (IDLE) before the next.
REQ-033 A requester that is high in IDLE during its done/err cycle SHALL be treated as a new request.

Reset
REQ-034 With rst_n low at a clock edge, the FSM SHALL enter IDLE; cyc_o, stb_o, we_o, gnts, dones, errs SHALL be 0; adr_o, dat_o, rdata regs SHALL be 0; counter 0; last_srv = fetch.
REQ-035 Reset mid-transaction SHALL abandon it without done/err; a later ack_i SHALL be ignored.

Verification
REQ-036 Bench: if_req, if_addr=0x100, ack_i one cycle after stb_o with dat_i=0xA5A5 -> adr_o=0x100, we_o=0, if_rdata=0xA5A5, if_done one cycle, total 3 cycles.
REQ-037 Bench: d_req and if_req both high out of reset -> data served first, then fetch, stb_o low one cycle between.
REQ-038 Bench: store d_addr=0x20, d_wdata=0x1234 -> we_o=1, dat_o=0x1234, d_done pulse, d_rdata unchanged.
REQ-039 Bench: TIMEOUT=3, ack_i held low -> stb_o high 4 cycles, d_err one pulse, no d_done, FSM in IDLE.
REQ-040 Bench: rst_n low for one cycle while in D_BUS, then ack_i -> all outputs 0, no done/err, ack ignored.

Source files
------------

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: instruction fetch and load/store ports share one
// single-outstanding bus, with fair alternation on contention and an ack timeout.
module mem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_err,

  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_BUS = 2'd1,
    D_BUS  = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       last_d;     // 1: data port was the most recently completed requester
  logic       d_wins;
  logic       bus_end;

  // On contention the requester that was not served last wins; reset leaves
  // last_d = 0 (fetch), so a tie straight out of reset goes to the data port.
  assign d_wins  = d_req && (!if_req || !last_d);
  assign bus_end = ack_i || (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      last_d   <= 1'b0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_done  <= 1'b0;
      if_err   <= 1'b0;
      d_done   <= 1'b0;
      d_err    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      // NOTE: non-blocking defaults here make done/err single-cycle pulses; a
      // later assignment in the same block overrides them for this edge only.
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (d_wins) begin
            state    <= D_BUS;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            d_gnt    <= 1'b1;
            we_o     <= d_we;
            adr_o    <= d_addr;
            dat_o    <= d_wdata;
            wait_cnt <= '0;
          end else if (if_req) begin
            state    <= IF_BUS;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            if_gnt   <= 1'b1;
            we_o     <= 1'b0;
            adr_o    <= if_addr;
            wait_cnt <= '0;
          end
        end

        IF_BUS, D_BUS: begin
          if (bus_end) begin
            // ack wins over a simultaneous timeout
            state  <= IDLE;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            we_o   <= 1'b0;
            if_gnt <= 1'b0;
            d_gnt  <= 1'b0;
            last_d <= (state == D_BUS);
            if (state == D_BUS) begin
              if (ack_i) begin
                d_done <= 1'b1;
                if (!we_o) d_rdata <= dat_i;
              end else begin
                d_err <= 1'b1;
              end
            end else begin
              if (ack_i) begin
                if_done  <= 1'b1;
                if_rdata <= dat_i;
              end else begin
                if_err <= 1'b1;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios followed by randomized
// traffic checked against a transaction-level arbitration/timeout model.
module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_gnt, if_done, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          cyc_o, stb_o, we_o, ack_i;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o, dat_i;

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic          m_last_d;
  logic [DW-1:0] m_if_rdata, m_d_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {55'd0, cyc_o, stb_o, we_o, if_gnt, d_gnt, if_done, if_err, d_done, d_err}, 64'd0);
    check({tag, "_if_rdata"}, if_rdata, m_if_rdata);
    check({tag, "_d_rdata"}, d_rdata, m_d_rdata);
  endtask

  task automatic check_reset(input string tag);
    m_last_d   = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    check_quiet(tag);
    check({tag, "_adr"}, adr_o, 64'd0);
    check({tag, "_dat"}, dat_o, 64'd0);
  endtask

  // One transaction starting with the DUT in IDLE and at least one request
  // driven. k = bus cycles before ack; k > TO means the slave never acks.
  task automatic txn(input int k, input logic [DW-1:0] rd, output logic won_d);
    logic          wd, wwe, acked;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdat;
    int            n_wait;
    wd    = d_req && (!if_req || !m_last_d);
    wwe   = wd ? d_we : 1'b0;
    wadr  = wd ? d_addr : if_addr;
    wdat  = d_wdata;
    acked = (k <= TO);
    step();
    check("grant", {59'd0, cyc_o, stb_o, if_gnt, d_gnt, we_o}, {59'd0, 1'b1, 1'b1, !wd, wd, wwe});
    check("grant_adr", adr_o, wadr);
    if (wd && wwe) check("grant_dat", dat_o, wdat);
    check("grant_no_pulse", {60'd0, if_done, if_err, d_done, d_err}, 64'd0);
    // inputs moving mid-transaction must not disturb the latched request
    if_addr = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_we    = 1'($urandom_range(1));
    n_wait  = (k > TO) ? TO : k;
    for (int i = 0; i < n_wait; i++) begin
      ack_i = 1'b0;
      dat_i = $urandom;
      step();
      check("wait_ctl", {58'd0, cyc_o, stb_o, if_done, if_err, d_done, d_err}, {58'd0, 6'b110000});
      check("wait_adr", adr_o, wadr);
      check("wait_we", we_o, wwe);
    end
    dat_i = rd;
    ack_i = acked;
    step();
    ack_i = 1'b0;
    dat_i = $urandom;
    if (acked && wd && !wwe) m_d_rdata = rd;
    if (acked && !wd) m_if_rdata = rd;
    m_last_d = wd;
    check("end_ctl", {55'd0, cyc_o, stb_o, we_o, if_gnt, d_gnt, if_done, if_err, d_done, d_err},
          {55'd0, 5'b00000, !wd && acked, !wd && !acked, wd && acked, wd && !acked});
    check("end_if_rdata", if_rdata, m_if_rdata);
    check("end_d_rdata", d_rdata, m_d_rdata);
    won_d = wd;
  endtask

  initial begin
    logic          w;
    logic [DW-1:0] old_rd;
    int            k;

    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    ack_i   = 1'b0;
    dat_i   = '0;
    step();
    step();
    check_reset("reset");
    rst_n = 1'b1;
    step();
    check_quiet("idle_after_reset");

    // both requesters out of reset: data first, then fetch, one idle cycle between
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h80;
    txn(1, 32'hDEAD_0001, w);
    check("tie_data_first", {63'd0, w}, 64'd1);
    d_req = 1'b0;
    txn(0, 32'hBEEF_0002, w);
    check("tie_fetch_second", {63'd0, w}, 64'd0);
    if_req = 1'b0;
    step();
    check_quiet("after_tie");

    // basic fetch, ack one cycle after strobe
    if_req = 1'b1; if_addr = 32'h100;
    txn(0, 32'hA5A5, w);
    check("fetch_rdata", if_rdata, 64'hA5A5);
    if_req = 1'b0;
    step();
    check_quiet("fetch_done_one_cycle");

    // store leaves d_rdata alone
    old_rd = m_d_rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
    txn(1, 32'h5555_AAAA, w);
    check("store_keeps_rdata", d_rdata, old_rd);
    d_req = 1'b0;
    step();
    check_quiet("after_store");

    // timeout: strobe held TO+1 cycles then d_err
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    txn(TO + 2, 32'h0BAD_0BAD, w);
    d_req = 1'b0;
    step();
    check_quiet("after_timeout");

    // ack in IDLE ignored
    for (int i = 0; i < 3; i++) begin
      ack_i = 1'b1;
      dat_i = $urandom;
      step();
      check_quiet("idle_ack");
    end
    ack_i = 1'b0;

    // fetch held through done is a new request
    if_req = 1'b1; if_addr = 32'h400;
    txn(0, 32'h1111_2222, w);
    if_addr = 32'h404;
    txn(2, 32'h3333_4444, w);
    check("rerequest_fetch", {63'd0, w}, 64'd0);
    if_req = 1'b0;
    step();
    check_quiet("after_rerequest");

    // reset mid-transaction, late ack ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    step();
    check("mid_gnt", {62'd0, d_gnt, stb_o}, 64'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    d_req = 1'b0;
    check_reset("mid_reset");
    ack_i = 1'b1;
    dat_i = 32'hFFFF_FFFF;
    step();
    check_quiet("late_ack_1");
    step();
    check_quiet("late_ack_2");
    ack_i = 1'b0;

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      if (!if_req && $urandom_range(1) == 1) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end
      if (!if_req && !d_req) begin
        ack_i = 1'($urandom_range(1));
        dat_i = $urandom;
        step();
        ack_i = 1'b0;
        check_quiet("rand_idle");
        continue;
      end
      k = $urandom_range(0, TO + 2);
      txn(k, $urandom, w);
      if ($urandom_range(3) != 0) begin
        if (w) d_req = 1'b0;
        else if_req = 1'b0;
      end else if (w) begin
        d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end else begin
        if_addr = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
